// File: rtl/motor_cmd_ramp.sv
// Duty slew-rate limiter with decel/dead-time/flip sequencing ahead of motor_controller.
// Optional command-loss watchdog: define MOTOR_RAMP_WATCHDOG_EN.
module motor_cmd_ramp #(
  parameter int unsigned DUTY_W         = 10,
  parameter int unsigned STEP           = 8,
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned REV_HOLD_TICKS = 20,
  parameter int unsigned WDOG_TICKS     = 500
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              estop,
  output logic              mc_dir,
  output logic [DUTY_W-1:0] mc_duty,
  output logic              at_target,
  output logic              reversing
);

  localparam int unsigned EW   = DUTY_W + 1;
  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HC_W = (REV_HOLD_TICKS > 1) ? $clog2(REV_HOLD_TICKS) : 1;

  if (TICK_DIV < 1 || STEP < 1 || REV_HOLD_TICKS < 1 || WDOG_TICKS < 1) begin : g_bad_params
    $error("motor_cmd_ramp: TICK_DIV, STEP, REV_HOLD_TICKS and WDOG_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {ST_RUN, ST_DECEL, ST_HOLD} state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   prescaler_q, prescaler_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DUTY_W-1:0] mc_duty_q, mc_duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] pend_target_q, pend_target_d;
  logic              mc_dir_q, mc_dir_d;
  logic              pend_dir_q, pend_dir_d;

  logic              tick;
  logic              accept;
  logic              wdog_fire;
  logic [EW-1:0]     duty_x, tgt_x, ramp_x;
  logic [DUTY_W-1:0] ramp_duty;

  assign tick      = (prescaler_q == PS_W'(TICK_DIV - 1));
  assign cmd_ready = (state_q != ST_HOLD) && !estop;
  assign accept    = cmd_valid && cmd_ready;

  assign mc_dir    = mc_dir_q;
  assign mc_duty   = mc_duty_q;
  assign at_target = (state_q == ST_RUN) && (mc_duty_q == target_q);
  assign reversing = (state_q == ST_DECEL) || (state_q == ST_HOLD);

  // One slew step toward the current target, in widened arithmetic.
  always_comb begin
    duty_x = {1'b0, mc_duty_q};
    tgt_x  = {1'b0, target_q};
    if (tgt_x > duty_x) begin
      ramp_x = ((tgt_x - duty_x) <= EW'(STEP)) ? tgt_x : duty_x + EW'(STEP);
    end else begin
      ramp_x = ((duty_x - tgt_x) <= EW'(STEP)) ? tgt_x : duty_x - EW'(STEP);
    end
    ramp_duty = DUTY_W'(ramp_x);
  end

`ifdef MOTOR_RAMP_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_TICKS + 1);
  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;

  // Ticks since last accepted command, saturating; fires once on reaching the limit.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    wdog_fire  = 1'b0;
    if (accept) begin
      wdog_cnt_d = '0;
    end else if (tick && (wdog_cnt_q != WD_W'(WDOG_TICKS))) begin
      wdog_cnt_d = wdog_cnt_q + WD_W'(1);
      wdog_fire  = (wdog_cnt_q == WD_W'(WDOG_TICKS - 1));
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) wdog_cnt_q <= '0;
    else       wdog_cnt_q <= wdog_cnt_d;
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_comb begin
    prescaler_d   = tick ? '0 : prescaler_q + PS_W'(1);
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    mc_duty_d     = mc_duty_q;
    target_d      = target_q;
    pend_target_d = pend_target_q;
    mc_dir_d      = mc_dir_q;
    pend_dir_d    = pend_dir_q;

    if (estop) begin
      mc_duty_d     = '0;
      target_d      = '0;
      pend_target_d = '0;
      pend_dir_d    = mc_dir_q;
      hold_cnt_d    = '0;
      state_d       = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (tick) mc_duty_d = ramp_duty;
          if (accept) begin
            if (cmd_duty == '0) begin
              target_d = '0;
            end else if (cmd_dir == mc_dir_q) begin
              target_d = cmd_duty;
            end else begin
              pend_dir_d    = cmd_dir;
              pend_target_d = cmd_duty;
              target_d      = '0;
              state_d       = ST_DECEL;
            end
          end
        end
        ST_DECEL: begin
          if (tick) mc_duty_d = ramp_duty;
          if (accept && (cmd_dir == mc_dir_q)) begin
            target_d      = cmd_duty;
            pend_target_d = '0;
            pend_dir_d    = mc_dir_q;
            state_d       = ST_RUN;
          end else begin
            if (accept) pend_target_d = cmd_duty;
            if (mc_duty_d == '0) begin
              hold_cnt_d = '0;
              state_d    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          mc_duty_d = '0;
          if (tick) begin
            if (hold_cnt_q == HC_W'(REV_HOLD_TICKS - 1)) begin
              mc_dir_d   = pend_dir_q;
              target_d   = pend_target_q;
              hold_cnt_d = '0;
              state_d    = ST_RUN;
            end else begin
              hold_cnt_d = hold_cnt_q + HC_W'(1);
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    // Command loss: drop target and abandon any reversal in progress.
    if (wdog_fire) begin
      target_d      = '0;
      pend_target_d = '0;
      pend_dir_d    = mc_dir_q;
      mc_dir_d      = mc_dir_q;
      hold_cnt_d    = '0;
      state_d       = ST_RUN;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      prescaler_q   <= '0;
      hold_cnt_q    <= '0;
      mc_duty_q     <= '0;
      target_q      <= '0;
      pend_target_q <= '0;
      mc_dir_q      <= 1'b1;
      pend_dir_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      prescaler_q   <= prescaler_d;
      hold_cnt_q    <= hold_cnt_d;
      mc_duty_q     <= mc_duty_d;
      target_q      <= target_d;
      pend_target_q <= pend_target_d;
      mc_dir_q      <= mc_dir_d;
      pend_dir_q    <= pend_dir_d;
    end
  end

endmodule
